// File: rtl/u_dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package u_dmem_arb_pkg;

  typedef enum logic {S_PIPE, S_DBG_LOCK} arb_state_t;

  localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h1000_0000;
  localparam int unsigned DMEM_DEPTH_DEFAULT = 256;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  // In-window and, for word accesses, naturally aligned.
  function automatic logic addr_legal(input logic [31:0] addr, input logic word,
                                      input logic [31:0] base, input int unsigned depth);
    logic [32:0] limit;
    limit = {1'b0, base} + 33'(4 * depth);
    return (addr >= base) && ({1'b0, addr} < limit) && !(word && (addr[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/u_dmem_arb_starve_cnt.sv
// Saturating wait counter for the debug port; flags when debug has waited long enough.
module u_dmem_arb_starve_cnt
  import u_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic forced
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign forced = (cnt_q == CntW'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !forced) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/u_dmem_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage and a debug/loader port,
// with debug burst locking, starvation forcing and address legality checking.
module u_dmem_arbiter
  import u_dmem_arb_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
  parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        i_sys_clock,
  input  logic        i_sys_reset,
  input  logic        i_u_dmem_arb_pipe_req,
  input  logic        i_u_dmem_arb_pipe_wr,
  input  logic        i_u_dmem_arb_pipe_word,
  input  logic [31:0] i_u_dmem_arb_pipe_addr,
  input  logic [31:0] i_u_dmem_arb_pipe_wdata,
  output logic [31:0] o_u_dmem_arb_pipe_rdata,
  output logic        o_u_dmem_arb_pipe_stall,
  input  logic        i_u_dmem_arb_dbg_req,
  input  logic        i_u_dmem_arb_dbg_lock,
  input  logic        i_u_dmem_arb_dbg_wr,
  input  logic        i_u_dmem_arb_dbg_word,
  input  logic [31:0] i_u_dmem_arb_dbg_addr,
  input  logic [31:0] i_u_dmem_arb_dbg_wdata,
  output logic        o_u_dmem_arb_dbg_gnt,
  output logic [31:0] o_u_dmem_arb_dbg_rdata,
  output logic        o_u_dmem_arb_dbg_rvalid,
  output logic        o_u_dmem_arb_err,
  output logic [31:0] o_u_dmem_arb_mem_addr,
  output logic [31:0] o_u_dmem_arb_mem_wdata,
  output logic        o_u_dmem_arb_mem_wr,
  output logic        o_u_dmem_arb_mem_word,
  input  logic [31:0] i_u_dmem_arb_mem_rdata
);

  arb_state_t  state_q, state_d;
  logic        forced;
  logic        gnt, stall;
  logic        pipe_go;
  logic [31:0] sel_addr;
  logic        sel_word;
  logic        sel_legal;
  logic        access;
  logic [31:0] rd_data;
  logic        err_q, rvalid_q;
  logic [31:0] rdata_q;

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_PIPE: begin
        gnt   = i_u_dmem_arb_dbg_req && (!i_u_dmem_arb_pipe_req || forced);
        stall = i_u_dmem_arb_pipe_req && gnt;
        if (gnt && i_u_dmem_arb_dbg_lock) state_d = S_DBG_LOCK;
      end
      S_DBG_LOCK: begin
        // Pipeline is held for the whole burst, even in gaps between debug requests.
        gnt   = i_u_dmem_arb_dbg_req;
        stall = i_u_dmem_arb_pipe_req;
        if (!i_u_dmem_arb_dbg_lock || !i_u_dmem_arb_dbg_req) state_d = S_PIPE;
      end
    endcase
  end

  u_dmem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk   (i_sys_clock),
    .rst   (i_sys_reset),
    .inc   (i_u_dmem_arb_dbg_req && !gnt),
    .clr   (!i_u_dmem_arb_dbg_req || gnt),
    .forced(forced)
  );

  // A stalled pipeline access is not performed, so it must not write or flag errors.
  assign pipe_go   = i_u_dmem_arb_pipe_req && !stall;
  assign sel_addr  = gnt ? i_u_dmem_arb_dbg_addr : i_u_dmem_arb_pipe_addr;
  assign sel_word  = gnt ? i_u_dmem_arb_dbg_word : i_u_dmem_arb_pipe_word;
  assign sel_legal = addr_legal(sel_addr, sel_word, DMEM_BASE, DMEM_DEPTH);
  assign access    = gnt || pipe_go;
  assign rd_data   = sel_legal ? i_u_dmem_arb_mem_rdata : 32'h0;

  assign o_u_dmem_arb_mem_addr  = sel_addr;
  assign o_u_dmem_arb_mem_word  = sel_word;
  assign o_u_dmem_arb_mem_wdata = gnt ? i_u_dmem_arb_dbg_wdata : i_u_dmem_arb_pipe_wdata;
  assign o_u_dmem_arb_mem_wr    = sel_legal &&
                                  (gnt ? i_u_dmem_arb_dbg_wr : (pipe_go && i_u_dmem_arb_pipe_wr));

  assign o_u_dmem_arb_pipe_rdata = rd_data;
  assign o_u_dmem_arb_pipe_stall = stall;
  assign o_u_dmem_arb_dbg_gnt    = gnt;
  assign o_u_dmem_arb_dbg_rdata  = rdata_q;
  assign o_u_dmem_arb_dbg_rvalid = rvalid_q;
  assign o_u_dmem_arb_err        = err_q;

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      state_q  <= S_PIPE;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_q || (access && !sel_legal);
      rvalid_q <= gnt && !i_u_dmem_arb_dbg_wr;
      if (gnt && !i_u_dmem_arb_dbg_wr) rdata_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_u_dmem_arbiter.sv
// Bench for u_dmem_arbiter: behavioural data memory, reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_u_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 256;
  localparam int          SMAX  = 4;

  logic        clk, rst;
  logic        pipe_req, pipe_wr, pipe_word;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        dbg_req, dbg_lock, dbg_wr, dbg_word;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_gnt, dbg_rvalid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, mem_word;

  int n_cmp = 0;
  int n_fail = 0;

  u_dmem_arbiter #(
    .DMEM_BASE (BASE),
    .DMEM_DEPTH(DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .i_sys_clock            (clk),
    .i_sys_reset            (rst),
    .i_u_dmem_arb_pipe_req  (pipe_req),
    .i_u_dmem_arb_pipe_wr   (pipe_wr),
    .i_u_dmem_arb_pipe_word (pipe_word),
    .i_u_dmem_arb_pipe_addr (pipe_addr),
    .i_u_dmem_arb_pipe_wdata(pipe_wdata),
    .o_u_dmem_arb_pipe_rdata(pipe_rdata),
    .o_u_dmem_arb_pipe_stall(pipe_stall),
    .i_u_dmem_arb_dbg_req   (dbg_req),
    .i_u_dmem_arb_dbg_lock  (dbg_lock),
    .i_u_dmem_arb_dbg_wr    (dbg_wr),
    .i_u_dmem_arb_dbg_word  (dbg_word),
    .i_u_dmem_arb_dbg_addr  (dbg_addr),
    .i_u_dmem_arb_dbg_wdata (dbg_wdata),
    .o_u_dmem_arb_dbg_gnt   (dbg_gnt),
    .o_u_dmem_arb_dbg_rdata (dbg_rdata),
    .o_u_dmem_arb_dbg_rvalid(dbg_rvalid),
    .o_u_dmem_arb_err       (err),
    .o_u_dmem_arb_mem_addr  (mem_addr),
    .o_u_dmem_arb_mem_wdata (mem_wdata),
    .o_u_dmem_arb_mem_wr    (mem_wr),
    .o_u_dmem_arb_mem_word  (mem_word),
    .i_u_dmem_arb_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge, little-endian lanes.
  logic [31:0] env_mem [DEPTH];
  logic [7:0]  env_idx;
  logic [31:0] env_word_val;
  assign env_idx      = 8'((mem_addr - BASE) >> 2);
  assign env_word_val = env_mem[env_idx];
  assign mem_rdata    = mem_word ? env_word_val
                                 : {24'h0, 8'(env_word_val >> {mem_addr[1:0], 3'b000})};

  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_word) env_mem[env_idx] <= mem_wdata;
      else env_mem[env_idx][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] mdl_mem [DEPTH];
  bit          m_locked, m_err, m_rvalid;
  int          m_wait;
  logic [31:0] m_rdata;

  function automatic bit legal(input logic [31:0] addr, input bit word);
    longint a;
    a = longint'(addr);
    return a >= longint'(BASE) && a < longint'(BASE) + 4 * DEPTH && (!word || a % 4 == 0);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] addr, input bit word);
    logic [31:0] w;
    w = mdl_mem[int'((addr - BASE) / 4)];
    if (word) return w;
    return (w >> (8 * (addr % 4))) & 32'hff;
  endfunction

  task automatic mdl_write(input logic [31:0] addr, input bit word, input logic [31:0] d);
    int idx;
    int lane;
    idx  = int'((addr - BASE) / 4);
    lane = int'(addr % 4);
    if (word) mdl_mem[idx] = d;
    else mdl_mem[idx][8 * lane +: 8] = d[7:0];
  endtask

  initial begin : model
    bit          e_gnt, e_stall, e_go, e_word, e_legal, e_wr;
    logic [31:0] e_addr, e_wdata, e_rd;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_locked = 0;
        m_wait   = 0;
        m_err    = 0;
        m_rvalid = 0;
        m_rdata  = 32'h0;
      end else begin
        if (m_locked) begin
          e_gnt   = dbg_req;
          e_stall = pipe_req;
        end else begin
          e_gnt   = dbg_req && (!pipe_req || m_wait == SMAX);
          e_stall = pipe_req && e_gnt;
        end
        e_go    = pipe_req && !e_stall;
        e_addr  = e_gnt ? dbg_addr : pipe_addr;
        e_word  = e_gnt ? dbg_word : pipe_word;
        e_wdata = e_gnt ? dbg_wdata : pipe_wdata;
        e_legal = legal(e_addr, e_word);
        e_wr    = e_legal && (e_gnt ? dbg_wr : (e_go && pipe_wr));
        e_rd    = e_legal ? mdl_read(e_addr, e_word) : 32'h0;

        check("m_gnt", dbg_gnt, e_gnt);
        check("m_stall", pipe_stall, e_stall);
        check("m_mem_addr", mem_addr, e_addr);
        check("m_mem_word", mem_word, e_word);
        check("m_mem_wr", mem_wr, e_wr);
        if (e_wr) check("m_mem_wdata", mem_wdata, e_wdata);
        if (e_go && !pipe_wr) check("m_pipe_rdata", pipe_rdata, e_rd);
        check("m_rvalid", dbg_rvalid, m_rvalid);
        check("m_dbg_rdata", dbg_rdata, m_rdata);
        check("m_err", err, m_err);

        if ((e_gnt || e_go) && !e_legal) m_err = 1;
        m_rvalid = e_gnt && !dbg_wr;
        if (m_rvalid) m_rdata = e_rd;
        if (e_wr) mdl_write(e_addr, e_word, e_wdata);
        if (!dbg_req || e_gnt) m_wait = 0;
        else if (m_wait < SMAX) m_wait++;
        m_locked = m_locked ? (dbg_req && dbg_lock) : (e_gnt && dbg_lock);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pipe_req = 0; pipe_wr = 0; pipe_word = 1; pipe_addr = BASE; pipe_wdata = 0;
    dbg_req = 0; dbg_lock = 0; dbg_wr = 0; dbg_word = 1; dbg_addr = BASE; dbg_wdata = 0;
  endtask

  initial begin : stim
    int k;
    for (int i = 0; i < DEPTH; i++) env_mem[i] = 32'h0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", pipe_stall, 0);
    check("rst_gnt", dbg_gnt, 0);
    check("rst_rvalid", dbg_rvalid, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_err", err, 0);
    #1 rst = 1'b0;
    tick();

    // 1: pipe word write then read back
    pipe_req = 1; pipe_wr = 1; pipe_word = 1; pipe_addr = BASE; pipe_wdata = 32'h8765_4321;
    #1;
    check("t1_wr_stall", pipe_stall, 0);
    check("t1_wr_gnt", dbg_gnt, 0);
    check("t1_mem_wr", mem_wr, 1);
    tick();
    pipe_wr = 0;
    #1;
    check("t1_rdata", pipe_rdata, 32'h8765_4321);
    check("t1_rd_stall", pipe_stall, 0);
    tick();

    // 2: debug byte write in an idle pipe cycle, then word read of the same word
    pipe_req = 0;
    dbg_req = 1; dbg_wr = 1; dbg_word = 0; dbg_addr = 32'h1000_0005; dbg_wdata = 32'hff;
    #1;
    check("t2_wr_gnt", dbg_gnt, 1);
    tick();
    dbg_wr = 0; dbg_word = 1; dbg_addr = 32'h1000_0004;
    #1;
    check("t2_rd_gnt", dbg_gnt, 1);
    tick();
    dbg_req = 0;
    #1;
    check("t2_rvalid", dbg_rvalid, 1);
    check("t2_dbg_rdata", dbg_rdata, 32'h0000_ff00);
    tick();

    // 3: starvation forces exactly one grant in cycle 4
    pipe_req = 1; pipe_wr = 0; pipe_addr = BASE;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h1000_0004;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t3_gnt_c%0d", i), dbg_gnt, (i == 4) ? 1 : 0);
      check($sformatf("t3_stall_c%0d", i), pipe_stall, (i == 4) ? 1 : 0);
      tick();
    end
    dbg_req = 0;
    tick();

    // 4: locked read burst while the pipeline keeps requesting
    dbg_req = 1; dbg_lock = 1; dbg_wr = 0; dbg_addr = BASE;
    #1;
    k = 0;
    while (dbg_gnt !== 1'b1 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("t4_first_gnt_seen", (k < 10) ? 1 : 0, 1);
    check("t4_stall_b0", pipe_stall, 1);
    tick();
    dbg_addr = 32'h1000_0004;
    #1;
    check("t4_rvalid_b0", dbg_rvalid, 1);
    check("t4_rdata_b0", dbg_rdata, 32'h8765_4321);
    check("t4_stall_b1", pipe_stall, 1);
    tick();
    dbg_addr = 32'h1000_0008; dbg_lock = 0;
    #1;
    check("t4_rdata_b1", dbg_rdata, 32'h0000_ff00);
    check("t4_stall_b2", pipe_stall, 1);
    check("t4_gnt_b2", dbg_gnt, 1);
    tick();
    dbg_req = 0;
    #1;
    check("t4_rvalid_b2", dbg_rvalid, 1);
    check("t4_unlocked_stall", pipe_stall, 0);
    tick();

    // 5: illegal pipeline writes are suppressed and flagged
    pipe_req = 1; pipe_wr = 1; pipe_word = 1; pipe_addr = 32'h1000_0002;
    pipe_wdata = 32'hdead_beef;
    #1;
    check("t5_misal_mem_wr", mem_wr, 0);
    check("t5_err_before", err, 0);
    tick();
    pipe_addr = 32'h0fff_fffc;
    #1;
    check("t5_err_after", err, 1);
    check("t5_oor_mem_wr", mem_wr, 0);
    tick();
    pipe_wr = 0; pipe_addr = BASE;
    #1;
    check("t5_mem_unchanged", pipe_rdata, 32'h8765_4321);
    tick();
    pipe_addr = 32'h0fff_fffc;
    #1;
    check("t5_oor_rdata", pipe_rdata, 32'h0);
    tick();

    // 6: reset in the second cycle of a lock burst
    pipe_req = 0;
    dbg_req = 1; dbg_lock = 1; dbg_wr = 0; dbg_word = 1; dbg_addr = BASE;
    #1;
    check("t6_gnt_b0", dbg_gnt, 1);
    tick();
    pipe_req = 1; pipe_wr = 0; pipe_addr = 32'h1000_0004; dbg_addr = 32'h1000_0004;
    #1;
    check("t6_stall_b1", pipe_stall, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_stall", pipe_stall, 0);
    check("t6_rst_gnt", dbg_gnt, 0);
    check("t6_rst_rvalid", dbg_rvalid, 0);
    check("t6_rst_err", err, 0);
    idle();
    @(posedge clk);
    #2 rst = 1'b0;
    pipe_req = 1; pipe_wr = 0; pipe_word = 1; pipe_addr = BASE;
    #1;
    check("t6_post_rdata", pipe_rdata, 32'h8765_4321);
    check("t6_post_stall", pipe_stall, 0);
    tick();
    idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
